// File: rtl/upload_pkg.sv
// Shared definitions for the SDRAM upload SPI slave: command codes, upload FSM
// encoding and CMD_INFO response byte indices.
package upload_pkg;

    localparam logic [7:0] CMD_INFO  = 8'h56;
    localparam logic [7:0] CMD_DATA  = 8'h57;
    localparam logic [7:0] FILL_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_FINISH
    } upload_state_t;

    localparam logic [2:0] INFO_STATUS = 3'd0;
    localparam logic [2:0] INFO_REM0   = 3'd1;
    localparam logic [2:0] INFO_REM1   = 3'd2;
    localparam logic [2:0] INFO_REM2   = 3'd3;
    localparam logic [2:0] INFO_CSUM   = 3'd4;

endpackage

// File: rtl/spi_slave_byte.sv
// Mode-0 SPI slave byte engine in the clk domain: synchronisers, edge detect,
// bit counter, rx/tx shifters and byte_rx / load_tx strobes.
module spi_slave_byte (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       ss,
    input  logic       sdi,
    output logic       sdo,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       byte_rx,
    output logic       cmd_phase,
    output logic       load_tx
);

    logic       sck_meta_q, sck_sync_q, sck_prev_q;
    logic       ss_meta_q, ss_sync_q;
    logic       sdi_meta_q, sdi_sync_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       sdo_q, sdo_d;
    logic       cmd_phase_q, cmd_phase_d;
    logic       load_pend_q, load_pend_d;
    logic       sck_rise, sck_fall;

    assign sck_rise  = sck_sync_q & ~sck_prev_q;
    assign sck_fall  = ~sck_sync_q & sck_prev_q;
    assign rx_byte   = {rx_q[6:0], sdi_sync_q};
    assign byte_rx   = ~ss_sync_q & sck_rise & (bit_cnt_q == 3'd7);
    assign load_tx   = ~ss_sync_q & sck_fall & load_pend_q;
    assign sdo       = sdo_q;
    assign cmd_phase = cmd_phase_q;

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        sdo_d       = sdo_q;
        cmd_phase_d = cmd_phase_q;
        load_pend_d = load_pend_q;
        if (ss_sync_q) begin
            bit_cnt_d   = 3'd0;
            tx_d        = 8'h00;
            sdo_d       = 1'b0;
            cmd_phase_d = 1'b1;
            load_pend_d = 1'b0;
        end else begin
            if (sck_rise) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    load_pend_d = 1'b1;
                    cmd_phase_d = 1'b0;
                end
            end
            // The first fall after a completed byte presents the next response MSB.
            if (sck_fall) begin
                if (load_pend_q) begin
                    sdo_d       = tx_byte[7];
                    tx_d        = {tx_byte[6:0], 1'b0};
                    load_pend_d = 1'b0;
                end else begin
                    sdo_d = tx_q[7];
                    tx_d  = {tx_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            sdi_meta_q  <= 1'b0;
            sdi_sync_q  <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            sdo_q       <= 1'b0;
            cmd_phase_q <= 1'b1;
            load_pend_q <= 1'b0;
        end else begin
            sck_meta_q  <= sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            ss_meta_q   <= ss;
            ss_sync_q   <= ss_meta_q;
            sdi_meta_q  <= sdi;
            sdi_sync_q  <= sdi_meta_q;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            sdo_q       <= sdo_d;
            cmd_phase_q <= cmd_phase_d;
            load_pend_q <= load_pend_d;
        end
    end

endmodule

// File: rtl/data_upload.sv
// Streams a core-selected SDRAM region to the IO controller over SPI.
// UPLOAD_CHECKSUM_EN adds a running 8-bit sum of sent bytes to CMD_INFO byte 4.
//
// state  | meaning
// IDLE   | no upload armed, waiting for start
// FETCH  | SDRAM read requested, waiting for ram_ack
// WAIT   | prefetch byte held, waiting for the SPI side to consume it
// FINISH | last byte consumed, pulse done and drop busy
module data_upload
    import upload_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int LEN_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              ss,
    input  logic              sdi,
    output logic              sdo,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    input  logic              ram_ack
);

    upload_state_t     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  offset_q, offset_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [7:0]        pf_data_q, pf_data_d;
    logic              pf_valid_q, pf_valid_d;
    logic              underrun_q, underrun_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [2:0]        resp_idx_q, resp_idx_d;
`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic [7:0] tx_byte, rx_byte;
    logic       byte_rx, cmd_phase, load_tx;
    logic       consume, underrun_set;

    spi_slave_byte u_spi (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .ss        (ss),
        .sdi       (sdi),
        .sdo       (sdo),
        .tx_byte   (tx_byte),
        .rx_byte   (rx_byte),
        .byte_rx   (byte_rx),
        .cmd_phase (cmd_phase),
        .load_tx   (load_tx)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_rd   = (state_q == ST_FETCH);
    assign ram_addr = base_q + ADDR_W'(offset_q);

    always_comb begin
        tx_byte      = FILL_BYTE;
        consume      = 1'b0;
        underrun_set = 1'b0;
        if (cmd_q == CMD_INFO) begin
            case (resp_idx_q)
                INFO_STATUS: tx_byte = {busy_q, underrun_q, 6'b0};
                INFO_REM0:   tx_byte = remaining_q[7:0];
                INFO_REM1:   tx_byte = remaining_q[15:8];
                INFO_REM2:   tx_byte = remaining_q[23:16];
`ifdef UPLOAD_CHECKSUM_EN
                INFO_CSUM:   tx_byte = csum_q;
`else
                INFO_CSUM:   tx_byte = 8'h00;
`endif
                default:     tx_byte = 8'h00;
            endcase
        end else if (cmd_q == CMD_DATA && busy_q) begin
            if (pf_valid_q) begin
                tx_byte = pf_data_q;
                consume = load_tx;
            end else begin
                tx_byte      = 8'h00;
                underrun_set = load_tx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        offset_d    = offset_q;
        remaining_d = remaining_q;
        pf_data_d   = pf_data_q;
        pf_valid_d  = pf_valid_q;
        underrun_d  = underrun_q | underrun_set;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cmd_d       = cmd_q;
        resp_idx_d  = resp_idx_q;
`ifdef UPLOAD_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        if (byte_rx && cmd_phase) begin
            cmd_d      = rx_byte;
            resp_idx_d = 3'd0;
        end else if (load_tx) begin
            resp_idx_d = (resp_idx_q == INFO_CSUM) ? 3'd0 : resp_idx_q + 3'd1;
        end

        if (consume) begin
            offset_d    = offset_q + LEN_W'(1);
            remaining_d = remaining_q - LEN_W'(1);
            pf_valid_d  = 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
            csum_d      = csum_q + pf_data_q;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d      = base;
                    offset_d    = '0;
                    remaining_d = length;
                    pf_valid_d  = 1'b0;
                    underrun_d  = 1'b0;
                    busy_d      = 1'b1;
`ifdef UPLOAD_CHECKSUM_EN
                    csum_d      = 8'h00;
`endif
                    state_d     = (length != '0) ? ST_FETCH : ST_FINISH;
                end
            end
            ST_FETCH: begin
                if (ram_ack) begin
                    pf_data_d  = ram_data;
                    pf_valid_d = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (consume) begin
                    state_d = (remaining_q == LEN_W'(1)) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            offset_q    <= '0;
            remaining_q <= '0;
            pf_data_q   <= 8'h00;
            pf_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_q       <= 8'h00;
            resp_idx_q  <= 3'd0;
`ifdef UPLOAD_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            offset_q    <= offset_d;
            remaining_q <= remaining_d;
            pf_data_q   <= pf_data_d;
            pf_valid_q  <= pf_valid_d;
            underrun_q  <= underrun_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_q       <= cmd_d;
            resp_idx_q  <= resp_idx_d;
`ifdef UPLOAD_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_data_upload.sv
// Directed bench for data_upload: SPI master, SDRAM responder and immediate
// assertions against hand-computed response bytes.
module tb_data_upload;

    localparam time HALF = 80ns;

`ifdef UPLOAD_CHECKSUM_EN
    localparam logic [7:0] CS_FULL = 8'hAA;
    localparam logic [7:0] CS_ONE  = 8'h11;
`else
    localparam logic [7:0] CS_FULL = 8'h00;
    localparam logic [7:0] CS_ONE  = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        reset, sck, ss, sdi, start;
    logic [24:0] base;
    logic [23:0] length;
    logic [7:0]  ram_data;
    logic        ram_ack;
    logic        sdo, busy, done, ram_rd;
    logic [24:0] ram_addr;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          slow_req = -1;
    int          r0, d0, ram_dly;
    logic [24:0] req_addr[$];
    logic [24:0] ram_a;
    logic [7:0]  rsp [0:7];
    logic [7:0]  cmd_echo;

    data_upload dut (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .ss       (ss),
        .sdi      (sdi),
        .sdo      (sdo),
        .start    (start),
        .base     (base),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .ram_rd   (ram_rd),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_ack  (ram_ack)
    );

    always #5ns clk = ~clk;

    always @(posedge clk) if (done === 1'b1) n_done <= n_done + 1;

    function automatic logic [7:0] mem(input logic [24:0] a);
        case (a)
            25'h01000: mem = 8'h11;
            25'h01001: mem = 8'h22;
            25'h01002: mem = 8'h33;
            25'h01003: mem = 8'h44;
            default:   mem = 8'hEE;
        endcase
    endfunction

    // SDRAM responder: ack 3 cycles after a request, or much later for slow_req.
    initial begin
        ram_ack  = 1'b0;
        ram_data = 8'h00;
        forever begin
            @(posedge clk); #1ns;
            if (ram_rd === 1'b1 && reset === 1'b0) begin
                ram_a = ram_addr;
                req_addr.push_back(ram_a);
                ram_dly = (req_addr.size() - 1 == slow_req) ? 400 : 3;
                repeat (ram_dly - 1) @(posedge clk);
                #1ns;
                ram_data = mem(ram_a);
                ram_ack  = 1'b1;
                @(posedge clk); #1ns;
                ram_ack  = 1'b0;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected end of test first");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Last byte of a frame: ss rises together with the final sck fall.
    task automatic spi_xfer(input logic [7:0] tx, input bit last, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            sdi = tx[i];
            #HALF;
            sck   = 1'b1;
            rx[i] = sdo;
            #HALF;
            if (i == 0 && last) ss = 1'b1;
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int n);
        logic [7:0] b;
        ss = 1'b0;
        #HALF;
        spi_xfer(cmd, n == 0, cmd_echo);
        for (int k = 0; k < n; k++) begin
            spi_xfer(8'h00, k == n - 1, b);
            rsp[k] = b;
        end
        #(4 * HALF);
    endtask

    task automatic pulse_start(input logic [24:0] b, input logic [23:0] l);
        @(negedge clk);
        base   = b;
        length = l;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ss = 1'b1; sck = 1'b0; sdi = 1'b0;
        start = 1'b0; base = '0; length = '0;
        repeat (3) @(negedge clk);
        chk("rst_sdo", sdo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ram_rd", ram_rd, 0);
        chk("rst_ram_addr", ram_addr, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // basic 4-byte upload
        r0 = req_addr.size();
        pulse_start(25'h01000, 24'd4);
        run_frame(8'h57, 4);
        chk("t1_cmd_sdo", cmd_echo, 8'h00);
        chk("t1_b0", rsp[0], 8'h11);
        chk("t1_b1", rsp[1], 8'h22);
        chk("t1_b2", rsp[2], 8'h33);
        chk("t1_b3", rsp[3], 8'h44);
        chk("t1_nreq", req_addr.size() - r0, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t1_addr%0d", k), req_addr[r0 + k], 25'h01000 + k);
        chk("t1_ndone", n_done, 1);
        chk("t1_busy", busy, 0);

        // extra data byte after the end, then status
        pulse_start(25'h01000, 24'd4);
        run_frame(8'h57, 5);
        chk("t2_b0", rsp[0], 8'h11);
        chk("t2_b3", rsp[3], 8'h44);
        chk("t2_b4_fill", rsp[4], 8'hFF);
        run_frame(8'h56, 5);
        chk("t2_info0", rsp[0], 8'h00);
        chk("t2_info1", rsp[1], 8'h00);
        chk("t2_info2", rsp[2], 8'h00);
        chk("t2_info3", rsp[3], 8'h00);
        chk("t2_csum", rsp[4], CS_FULL);
        chk("t2_ndone", n_done, 2);

        // slow second fetch -> underrun
        r0 = req_addr.size();
        slow_req = r0 + 1;
        pulse_start(25'h01000, 24'd4);
        run_frame(8'h57, 2);
        chk("t3_b0", rsp[0], 8'h11);
        chk("t3_underrun_byte", rsp[1], 8'h00);
        repeat (600) @(negedge clk);
        chk("t3_nreq", req_addr.size() - r0, 2);
        chk("t3_slow_addr", req_addr[r0 + 1], 25'h01001);
        run_frame(8'h56, 5);
        chk("t3_info0", rsp[0], 8'hC0);
        chk("t3_rem0", rsp[1], 8'h03);
        chk("t3_rem1", rsp[2], 8'h00);
        chk("t3_rem2", rsp[3], 8'h00);
        chk("t3_csum", rsp[4], CS_ONE);
        slow_req = -1;
        run_frame(8'h57, 3);
        chk("t3_retry", rsp[0], 8'h22);
        chk("t3_b2", rsp[1], 8'h33);
        chk("t3_b3", rsp[2], 8'h44);
        run_frame(8'h56, 5);
        chk("t3_sticky", rsp[0], 8'h40);
        chk("t3_csum_end", rsp[4], CS_FULL);
        chk("t3_ndone", n_done, 3);

        // zero length
        r0 = req_addr.size();
        @(negedge clk);
        base = 25'h01000; length = 24'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_busy_a", busy, 1);
        chk("t4_done_a", done, 0);
        @(negedge clk);
        chk("t4_done_b", done, 1);
        chk("t4_busy_b", busy, 0);
        @(negedge clk);
        chk("t4_done_c", done, 0);
        chk("t4_busy_c", busy, 0);
        chk("t4_nreq", req_addr.size() - r0, 0);
        chk("t4_ndone", n_done, 4);

        // reset mid-transfer
        pulse_start(25'h01000, 24'd4);
        run_frame(8'h57, 2);
        chk("t5_b0", rsp[0], 8'h11);
        chk("t5_b1", rsp[1], 8'h22);
        d0 = n_done;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_sdo", sdo, 0);
        chk("t5_ram_rd", ram_rd, 0);
        chk("t5_done", done, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_no_done", n_done, d0);
        run_frame(8'h56, 5);
        chk("t5_info0", rsp[0], 8'h00);
        chk("t5_info1", rsp[1], 8'h00);
        chk("t5_info2", rsp[2], 8'h00);
        chk("t5_info3", rsp[3], 8'h00);
        chk("t5_info4", rsp[4], 8'h00);

        // start while busy, partial byte on ss
        r0 = req_addr.size();
        d0 = n_done;
        pulse_start(25'h01000, 24'd4);
        run_frame(8'h57, 1);
        chk("t6_b0", rsp[0], 8'h11);
        pulse_start(25'h02000, 24'd2);
        chk("t6_busy", busy, 1);
        ss = 1'b0;
        #HALF;
        for (int i = 7; i >= 4; i--) begin
            sdi = 1'b1;
            #HALF; sck = 1'b1;
            #HALF; sck = 1'b0;
        end
        ss = 1'b1;
        #(4 * HALF);
        run_frame(8'h57, 3);
        chk("t6_b1", rsp[0], 8'h22);
        chk("t6_b2", rsp[1], 8'h33);
        chk("t6_b3", rsp[2], 8'h44);
        chk("t6_nreq", req_addr.size() - r0, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t6_addr%0d", k), req_addr[r0 + k], 25'h01000 + k);
        chk("t6_ndone", n_done - d0, 1);
        chk("t6_busy_end", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
